// File: rtl/x_mem_dump_pkg.sv
// Shared types and constants for the x_mem_dump block (optional header: X_MEM_DUMP_HDR_EN).
// Holds the dump FSM state enum, the header sync byte and the default widths.
package x_mem_dump_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [7:0] HDR_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_READ = 3'd2,
    ST_CAPT = 3'd3,
    ST_SEND = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/x_mem_dump_ser.sv
// Word-load, MSB-first byte serializer with a registered valid/ready source.
// Pulses o_last combinationally on the handshake of the final byte of a word.
module x_mem_dump_ser
  import x_mem_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  output logic              o_valid,
  output logic [7:0]        o_data,
  input  logic              i_ready,
  output logic              o_last
);

  localparam int NB    = bytes_per_word(DATA_W);
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              accept;

  // The shift register doubles as the word buffer; its top byte is always the one on offer.
  assign o_data = shreg[DATA_W-1 -: 8];
  assign accept = o_valid && i_ready;
  assign o_last = accept && (idx == IDX_W'(NB - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make simulation order-dependent.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg   <= '0;
      idx     <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      shreg   <= i_word;
      idx     <= '0;
      o_valid <= 1'b1;
    end else if (accept) begin
      shreg <= shreg << 8;
      if (o_last) begin
        idx     <= '0;
        o_valid <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/x_mem_dump.sv
// Memory dump initiator: reads a block of words and streams them MSB byte first.
// Define X_MEM_DUMP_HDR_EN to prefix each non-empty dump with 8'hA5 and (count-1)[7:0].
module x_mem_dump
  import x_mem_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ren,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_valid,
  output logic [7:0]        o_data,
  input  logic              i_ready
);

  localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   words_left;

  logic              ser_load;
  logic              ser_valid;
  logic [7:0]        ser_data;
  logic              ser_last;

  // Read data is valid exactly in CAPT, one cycle after the single-cycle o_ren.
  assign ser_load = (state == ST_CAPT);

  x_mem_dump_ser #(
    .DATA_W (DATA_W)
  ) u_ser (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ser_load),
    .i_word  (i_rdata),
    .o_valid (ser_valid),
    .o_data  (ser_data),
    .i_ready (i_ready),
    .o_last  (ser_last)
  );

`ifdef X_MEM_DUMP_HDR_EN
  logic       hdr_valid;
  logic [7:0] hdr_data;
  logic       hdr_second;

  assign o_valid = ser_valid | hdr_valid;
  assign o_data  = hdr_valid ? hdr_data : ser_data;
`else
  assign o_valid = ser_valid;
  assign o_data  = ser_data;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      addr       <= '0;
      words_left <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_ren      <= 1'b0;
      o_raddr    <= '0;
`ifdef X_MEM_DUMP_HDR_EN
      hdr_valid  <= 1'b0;
      hdr_data   <= '0;
      hdr_second <= 1'b0;
`endif
    end else begin
      // Pulsed outputs default low; only the state that owns them raises them.
      o_done <= 1'b0;
      o_ren  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            addr       <= i_base;
            words_left <= i_count;
            if (i_count == '0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              o_busy <= 1'b1;
`ifdef X_MEM_DUMP_HDR_EN
              state      <= ST_HDR;
              hdr_valid  <= 1'b1;
              hdr_data   <= HDR_SYNC;
              hdr_second <= 1'b0;
`else
              state   <= ST_READ;
              o_ren   <= 1'b1;
              o_raddr <= i_base;
`endif
            end
          end
        end

`ifdef X_MEM_DUMP_HDR_EN
        ST_HDR: begin
          if (i_ready) begin
            if (!hdr_second) begin
              hdr_second <= 1'b1;
              hdr_data   <= 8'(words_left - 1'b1);
            end else begin
              hdr_valid <= 1'b0;
              hdr_data  <= '0;
              state     <= ST_READ;
              o_ren     <= 1'b1;
              o_raddr   <= addr;
            end
          end
        end
`endif

        ST_READ: state <= ST_CAPT;

        ST_CAPT: state <= ST_SEND;

        ST_SEND: begin
          if (ser_last) begin
            if (words_left == ONE_WORD) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              // Address wraps naturally at 2**ADDR_W.
              words_left <= words_left - 1'b1;
              addr       <= addr + 1'b1;
              o_raddr    <= addr + 1'b1;
              o_ren      <= 1'b1;
              state      <= ST_READ;
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_mem_dump.sv
// Scoreboard bench for x_mem_dump: a reference model fills an expected-byte queue per dump,
// a negedge monitor pops and compares each accepted byte. Honours X_MEM_DUMP_HDR_EN.
module tb_x_mem_dump;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int NB     = DATA_W / 8;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W:0]   i_count;
  logic              o_busy;
  logic              o_done;
  logic              o_ren;
  logic [ADDR_W-1:0] o_raddr;
  logic [DATA_W-1:0] i_rdata;
  logic              o_valid;
  logic [7:0]        o_data;
  logic              i_ready;

  x_mem_dump #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_base  (i_base),
    .i_count (i_count),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_ren   (o_ren),
    .o_raddr (o_raddr),
    .i_rdata (i_rdata),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready)
  );

  always #5 i_clk = ~i_clk;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [7:0]        exp_q [$];
  logic [7:0]        ren_log [$];
  logic [7:0]        mon_exp;
  int                errors   = 0;
  int                checks   = 0;
  int                done_cnt = 0;
  int                acc_cnt  = 0;
  bit                rand_ready = 1'b0;
  logic              prev_stall = 1'b0;
  logic [7:0]        prev_data  = '0;

  // Registered-read memory: data appears the cycle after o_ren, X otherwise.
  always @(posedge i_clk) begin
    if (o_ren) i_rdata <= mem[o_raddr];
    else       i_rdata <= 'x;
  end

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the byte stream a dump must produce, straight from the memory image.
  function automatic int push_expected(input logic [ADDR_W-1:0] base, input int count);
    int n = 0;
    logic [ADDR_W:0]   cm1;
    logic [DATA_W-1:0] w;
`ifdef X_MEM_DUMP_HDR_EN
    if (count != 0) begin
      cm1 = (ADDR_W+1)'(count - 1);
      exp_q.push_back(8'hA5);
      exp_q.push_back(cm1[7:0]);
      n += 2;
    end
`endif
    for (int k = 0; k < count; k++) begin
      w = mem[(int'(base) + k) % (2**ADDR_W)];
      for (int b = NB - 1; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
        n++;
      end
    end
    return n;
  endfunction

  // Monitor: inputs only move just after posedge, so negedge values decide the next edge.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", o_valid && (o_data == prev_data), {23'd0, o_valid, o_data},
              {23'd0, 1'b1, prev_data});
      if (o_ren) ren_log.push_back(o_raddr);
      if (o_valid && i_ready) begin
        check("byte_expected", exp_q.size() != 0, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("byte", o_data == mon_exp, o_data, mon_exp);
        end
        acc_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        check("done_drain", (exp_q.size() == 0) && !o_busy, exp_q.size(), 0);
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic start_dump(input logic [ADDR_W-1:0] base, input int count, output int nbytes);
    nbytes = push_expected(base, count);
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_base  = base;
    i_count = (ADDR_W+1)'(count);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    @(negedge i_clk);
    check("done_count", done_cnt == target, done_cnt, target);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      @(posedge i_clk);
      #2;
      n++;
    end
    check("acc_timeout", acc_cnt >= target, acc_cnt, target);
  endtask

  initial begin
    int nb;
    int acc0;
    int dn0;
    int n;

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_base  = '0;
    i_count = '0;
    for (int a = 0; a < 2**ADDR_W; a++) mem[a] = DATA_W'($urandom);

    @(negedge i_clk);
    check("reset_outputs", {o_busy, o_done, o_ren, o_valid, o_raddr, o_data} == '0,
          {o_busy, o_done, o_ren, o_valid, o_raddr, o_data}, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Directed three-word dump at full throughput.
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'hABCD;
    mem[8'h12] = 16'h00FF;
    acc0 = acc_cnt;
    start_dump(8'h10, 3, nb);
    wait_done(1, 300);
    check("dump3_bytes", acc_cnt - acc0 == nb, acc_cnt - acc0, nb);

    // Start in the DONE cycle must be ignored.
    start_dump(8'h20, 1, nb);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_done && n < 200);
    check("done_seen", o_done, o_done, 1);
    ren_log.delete();
    dn0  = done_cnt + 1;
    acc0 = acc_cnt;
    i_start = 1'b1;
    i_base  = 8'h30;
    i_count = 9'd5;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (20) @(negedge i_clk);
    check("done_start_ign", !o_busy && ren_log.size() == 0 && acc_cnt == acc0,
          ren_log.size(), 0);
    check("done_start_cnt", done_cnt == dn0, done_cnt, dn0);

    // Address wrap at the top of memory.
    ren_log.delete();
    start_dump(8'hFF, 2, nb);
    wait_done(dn0 + 1, 300);
    check("wrap_ren_cycles", ren_log.size() == 2, ren_log.size(), 2);
    if (ren_log.size() == 2) begin
      check("wrap_addr0", ren_log[0] == 8'hFF, ren_log[0], 8'hFF);
      check("wrap_addr1", ren_log[1] == 8'h00, ren_log[1], 8'h00);
    end

    // Empty dump: done on the cycle after start, no read, no bytes.
    ren_log.delete();
    acc0 = acc_cnt;
    dn0  = done_cnt;
    start_dump(8'h33, 0, nb);
    @(negedge i_clk);
    check("empty_done", o_done && !o_busy, {o_done, o_busy}, 2'b10);
    repeat (10) @(negedge i_clk);
    check("empty_no_activity", ren_log.size() == 0 && acc_cnt == acc0, acc_cnt - acc0, 0);
    check("empty_done_cnt", done_cnt == dn0 + 1, done_cnt, dn0 + 1);

    // Full-memory dump under random backpressure.
    for (int a = 0; a < 2**ADDR_W; a++) mem[a] = DATA_W'($urandom);
    rand_ready = 1'b1;
    ren_log.delete();
    acc0 = acc_cnt;
    dn0  = done_cnt;
    start_dump(ADDR_W'($urandom), 256, nb);
    wait_done(dn0 + 1, 8000);
    check("full_bytes", acc_cnt - acc0 == nb, acc_cnt - acc0, nb);
    check("full_reads", ren_log.size() == 256, ren_log.size(), 256);

    // Start pulsed mid-dump is not queued.
    acc0 = acc_cnt;
    dn0  = done_cnt;
    start_dump(8'h40, 4, nb);
    wait_acc(acc0 + 2, 500);
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_base  = 8'h80;
    i_count = 9'd5;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done(dn0 + 1, 1000);
    repeat (30) @(negedge i_clk);
    check("restart_ignored", acc_cnt - acc0 == nb && done_cnt == dn0 + 1, acc_cnt - acc0, nb);

    // Synchronous reset after the third accepted byte: back to idle, no done.
    rand_ready = 1'b0;
    acc0 = acc_cnt;
    dn0  = done_cnt;
    start_dump(8'h50, 6, nb);
    wait_acc(acc0 + 3, 500);
    i_rst = 1'b1;
    exp_q.delete();
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("midreset_idle", {o_busy, o_done, o_ren, o_valid, o_raddr, o_data} == '0,
          {o_busy, o_done, o_ren, o_valid, o_raddr, o_data}, 0);
    repeat (30) @(negedge i_clk);
    check("midreset_no_done", done_cnt == dn0, done_cnt, dn0);

    // Recovery dump after the reset.
    acc0 = acc_cnt;
    start_dump(8'h60, 2, nb);
    wait_done(dn0 + 1, 300);
    check("recover_bytes", acc_cnt - acc0 == nb, acc_cnt - acc0, nb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
